median_line_sequencer: RTL and testbench
========================================

Name: median_line_sequencer

Overview:
- Sequences one line of detector samples from a source RAM through a 3-tap median window and writes the filtered line to a destination RAM.
- Drives the edge-replicated fetch order, window priming, result write-back, per-line window clear, abort and bypass.
- Sits between the acquisition line buffer and the readout buffer.
- Runs on the system clock and replaces ad-hoc LOAD/RST strobing of the median datapath.

Parameters:
- DW, 16, sample width in bits.
- AW, 10, RAM address width; maximum line length is 2^AW.

Ports:
- CLK  in  1  system clock, rising edge.
- HARD_RESET  in  1  reset, asynchronous, active-high.
- START  in  1  one-cycle pulse; begin processing a line. Ignored while BUSY.
- ABORT  in  1  synchronous; terminates the current line.
- BYPASS  in  1  sampled with START; 1 = write unfiltered samples.
- LEN  in  AW+1  line length N, sampled with START; valid range 0..2^AW.
- RD_EN  out  1  source RAM read strobe.
- RD_ADDR  out  AW  source RAM address.
- RD_DATA  in  DW  source data, valid exactly 1 cycle after RD_EN.
- WR_EN  out  1  destination RAM write strobe.
- WR_ADDR  out  AW  destination address.
- WR_DATA  out  DW  filtered sample.
- BUSY  out  1  line in progress.
- DONE  out  1  one-cycle pulse when a line completes.

Behaviour:
- Reset: all outputs 0, state IDLE, window taps 0, counters 0.
- Filter definition: out[j] = median(x[j-1], x[j], x[j+1]) for j = 0..N-1, with edge replication x[-1] = x[0] and x[N] = x[N-1].
- Median uses unsigned compare; ties resolve to the equal value; there is no arithmetic on samples.
- States: IDLE, FETCH, DRAIN, FIN.
- IDLE -> FETCH on START when LEN != 0.
  - On that START, latch LEN and BYPASS and clear the window.
- START with LEN = 0: no reads, no writes, DONE pulses the next cycle, BUSY stays 0.
- Timing reference: the START sample edge is cycle 0.
- FETCH (cycles 1..N+2): RD_EN = 1 every cycle.
  - RD_ADDR sequence: 0, 0, 1, ..., N-1, N-1 (N+2 reads).
  - For N = 1 the sequence is 0, 0, 0.
- Window load:
  - RD_DATA is shifted into the 3-tap window (tap2 <= tap1, tap1 <= tap0, tap0 <= RD_DATA) in the cycle after each read, i.e. cycles 2..N+3.
  - A fill counter (0..3) saturates at 3; window valid = fill == 3.
- DRAIN: entered after the last read; holds until the last write.
- Write-back:
  - Whenever the window is valid and was updated in the previous cycle, WR_EN = 1 for that cycle.
  - WR_ADDR = output index j, incrementing from 0.
  - WR_DATA = median(tap0, tap1, tap2), or tap1 when BYPASS is latched.
  - Writes occur in cycles 5..N+4, one per cycle, with no gaps.
- FIN: DONE = 1 for cycle N+5, then IDLE.
- BUSY = 1 in cycles 1..N+4.
- Throughput: one sample per clock; total line time N+5 cycles from START to DONE.
- ABORT when BUSY:
  - Next cycle is IDLE; RD_EN and WR_EN drop immediately (same-cycle combinational gating).
  - Window and fill counter cleared; no DONE.
  - Writes already issued stand.
- ABORT and START in the same cycle while IDLE: ABORT wins; the line does not start.
- START while BUSY: ignored, no effect on the latched LEN or BYPASS.
- HARD_RESET mid-line: immediate return to the reset state; no DONE.
- Counter widths: read and write indices are AW+1 bits so that N = 2^AW does not wrap early; addresses are the low AW bits.

Decomposition:
- Shared package holds:
  - DW, AW defaults.
  - State encoding constants ST_IDLE, ST_FETCH, ST_DRAIN, ST_FIN.
  - Fill-count constant WIN_TAPS = 3.
- One sub-module: median3_win.
  - Clocked 3-tap shift window with load, clear and fill counter.
  - Combinational median output and centre-tap output.
- The sequencer holds the FSM, the read and write address counters, and the handshake logic.

Test Plan:
- LEN=5, BYPASS=0, RAM = 10, 50, 20, 30, 40 -> writes at cycles 5..9: addr0=10, addr1=20, addr2=30, addr3=30, addr4=40; DONE at cycle 10; RD_ADDR sequence 0, 0, 1, 2, 3, 4, 4.
- LEN=1, RAM[0]=0xABCD -> three reads of addr 0; single write addr0=0xABCD at cycle 5; DONE at cycle 6.
- LEN=4, BYPASS=1, RAM = 7, 1, 9, 3 -> writes 7, 1, 9, 3 to addr 0..3 unchanged; timing identical to the filtered case.
- LEN=0 -> no RD_EN or WR_EN, BUSY stays 0, DONE at cycle 1. Then LEN=3 with RAM = 0xFFFF, 0, 0xFFFF -> outputs 0xFFFF, 0xFFFF, 0xFFFF.
- LEN=8, ABORT at cycle 6 -> exactly one write (addr0) completed; RD_EN and WR_EN low from cycle 6; no DONE. A following START with LEN=3 processes normally starting from a clean window.
- LEN=2^AW with a ramp pattern -> 2^AW writes equal to the ramp, last WR_ADDR = 2^AW-1. A START pulse at cycle 20 is ignored. HARD_RESET asserted mid-line -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/median_line_sequencer_pkg.sv
// Shared constants for the median line sequencer: default widths, FSM encoding, window depth.
package median_line_sequencer_pkg;
  localparam int DW_DEFAULT = 16;
  localparam int AW_DEFAULT = 10;
  localparam int WIN_TAPS   = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2,
    ST_FIN   = 2'd3
  } state_t;
endpackage

// File: rtl/median_line_sequencer_win.sv
// 3-tap shift window with fill counter; median and centre tap are combinational.
module median3_win
  import median_line_sequencer_pkg::*;
#(
  parameter int DW = DW_DEFAULT
) (
  input  logic          CLK,
  input  logic          HARD_RESET,
  input  logic          clr,
  input  logic          load,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] med,
  output logic [DW-1:0] ctr,
  output logic          valid
);
  logic [DW-1:0] tap0, tap1, tap2, lo, hi;
  logic [1:0]    fill;

  always_ff @(posedge CLK or posedge HARD_RESET) begin
    if (HARD_RESET) begin
      tap0 <= '0; tap1 <= '0; tap2 <= '0; fill <= '0;
    end else if (clr) begin
      tap0 <= '0; tap1 <= '0; tap2 <= '0; fill <= '0;
    end else if (load) begin
      tap2 <= tap1;
      tap1 <= tap0;
      tap0 <= din;
      if (fill != 2'(WIN_TAPS)) fill <= fill + 2'd1;
    end
  end

  // Median = tap2 clamped into [min(tap0,tap1), max(tap0,tap1)]; ties fall out naturally.
  always_comb begin
    lo  = (tap0 < tap1) ? tap0 : tap1;
    hi  = (tap0 < tap1) ? tap1 : tap0;
    med = (tap2 > hi) ? hi : ((tap2 < lo) ? lo : tap2);
  end

  assign ctr   = tap1;
  assign valid = (fill == 2'(WIN_TAPS));
endmodule

// File: rtl/median_line_sequencer.sv
// Fetches one line with edge replication, primes the median window and writes the filtered line back.
module median_line_sequencer
  import median_line_sequencer_pkg::*;
#(
  parameter int DW = DW_DEFAULT,
  parameter int AW = AW_DEFAULT
) (
  input  logic          CLK,
  input  logic          HARD_RESET,
  input  logic          START,
  input  logic          ABORT,
  input  logic          BYPASS,
  input  logic [AW:0]   LEN,
  output logic          RD_EN,
  output logic [AW-1:0] RD_ADDR,
  input  logic [DW-1:0] RD_DATA,
  output logic          WR_EN,
  output logic [AW-1:0] WR_ADDR,
  output logic [DW-1:0] WR_DATA,
  output logic          BUSY,
  output logic          DONE
);
  localparam int STAGES = 1;
  localparam logic [AW:0] ONE = 1;

  state_t        state, state_nx;
  logic [AW:0]   len_q, rd_cnt, wr_cnt, rd_a;
  logic          byp_q;
  logic [STAGES:0] vld_pipe;   // [0]: read issued last cycle (load now), [1]: window loaded last cycle
  logic          start_ok, in_line, win_clr, wr_fire, win_valid;
  logic [DW-1:0] win_med, win_ctr;

  assign start_ok = START && !ABORT && (state == ST_IDLE);
  assign in_line  = (state == ST_FETCH) || (state == ST_DRAIN);
  assign win_clr  = start_ok || (ABORT && in_line);
  assign wr_fire  = in_line && !ABORT && win_valid && vld_pipe[1];

  always_ff @(posedge CLK or posedge HARD_RESET) begin
    if (HARD_RESET) state <= ST_IDLE;
    else            state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:  if (start_ok) state_nx = (LEN == '0) ? ST_FIN : ST_FETCH;
      ST_FETCH: if (ABORT) state_nx = ST_IDLE;
                else if (rd_cnt == len_q + ONE) state_nx = ST_DRAIN;
      ST_DRAIN: if (ABORT) state_nx = ST_IDLE;
                else if (wr_fire && (wr_cnt == len_q - ONE)) state_nx = ST_FIN;
      ST_FIN:   state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    RD_EN = (state == ST_FETCH) && !ABORT;
    BUSY  = in_line;
    DONE  = (state == ST_FIN);
  end

  always_ff @(posedge CLK or posedge HARD_RESET) begin
    if (HARD_RESET) begin
      len_q <= '0; byp_q <= 1'b0; rd_cnt <= '0; wr_cnt <= '0; vld_pipe <= '0;
    end else begin
      if (start_ok) begin
        len_q <= LEN;
        byp_q <= BYPASS;
      end
      if (win_clr) begin
        rd_cnt   <= '0;
        wr_cnt   <= '0;
        vld_pipe <= '0;
      end else begin
        if (RD_EN)   rd_cnt <= rd_cnt + ONE;
        if (wr_fire) wr_cnt <= wr_cnt + ONE;
        vld_pipe <= {vld_pipe[STAGES-1:0], RD_EN};
      end
    end
  end

  // Read k fetches x[k-1] clamped to [0, N-1], giving 0,0,1,..,N-1,N-1.
  always_comb begin
    if (rd_cnt == '0)        rd_a = '0;
    else if (rd_cnt > len_q) rd_a = len_q - ONE;
    else                     rd_a = rd_cnt - ONE;
  end

  assign RD_ADDR = RD_EN ? rd_a[AW-1:0] : '0;
  assign WR_EN   = wr_fire;
  assign WR_ADDR = wr_fire ? wr_cnt[AW-1:0] : '0;
  assign WR_DATA = wr_fire ? (byp_q ? win_ctr : win_med) : '0;

  median3_win #(.DW(DW)) u_win (
    .CLK        (CLK),
    .HARD_RESET (HARD_RESET),
    .clr        (win_clr),
    .load       (vld_pipe[0]),
    .din        (RD_DATA),
    .med        (win_med),
    .ctr        (win_ctr),
    .valid      (win_valid)
  );
endmodule

// File: tb/tb_median_line_sequencer.sv
// Table-driven bench with a write scoreboard for the median line sequencer.
module tb_median_line_sequencer;
  localparam int DW = 16;
  localparam int AW = 10;

  logic          CLK = 1'b0;
  logic          HARD_RESET, START, ABORT, BYPASS;
  logic [AW:0]   LEN;
  logic          RD_EN, WR_EN, BUSY, DONE;
  logic [AW-1:0] RD_ADDR, WR_ADDR;
  logic [DW-1:0] RD_DATA, WR_DATA;

  median_line_sequencer #(.DW(DW), .AW(AW)) dut (
    .CLK(CLK), .HARD_RESET(HARD_RESET), .START(START), .ABORT(ABORT), .BYPASS(BYPASS),
    .LEN(LEN), .RD_EN(RD_EN), .RD_ADDR(RD_ADDR), .RD_DATA(RD_DATA), .WR_EN(WR_EN),
    .WR_ADDR(WR_ADDR), .WR_DATA(WR_DATA), .BUSY(BUSY), .DONE(DONE)
  );

  always #5 CLK = ~CLK;

  logic [DW-1:0] mem [0:(1<<AW)-1];
  always @(posedge CLK) if (RD_EN) RD_DATA <= mem[RD_ADDR];

  typedef struct { logic [AW-1:0] a; logic [DW-1:0] d; } wr_t;
  wr_t sb[$];

  typedef struct {
    int              n;
    bit              byp;
    logic [0:7][15:0] x;
    logic [0:7][15:0] y;
  } vec_t;
  vec_t tbl[8];

  int n_cmp = 0, n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge CLK) begin
    if (WR_EN === 1'b1) begin
      if (sb.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL wr_unexpected: got write addr %0h data %0h expected none", WR_ADDR, WR_DATA);
      end else begin
        wr_t e;
        e = sb.pop_front();
        chk("wr_addr", 32'(WR_ADDR), 32'(e.a));
        chk("wr_data", 32'(WR_DATA), 32'(e.d));
      end
    end
  end

  // One line from START; abort_at / start_at are cycle numbers (0 = unused).
  task automatic run_line(input int n, input bit byp, input int abort_at, input int start_at);
    int done_c;
    done_c = (n == 0) ? 1 : n + 5;
    @(negedge CLK);
    LEN = (AW+1)'(n); BYPASS = byp; START = 1'b1;
    @(posedge CLK); #1;
    START = 1'b0;
    for (int c = 1; c <= n + 7; c++) begin
      bit rd_e, wr_e, bz_e, dn_e, aborted;
      int ra;
      ABORT = (c == abort_at);
      if (c == start_at) begin START = 1'b1; LEN = 5; BYPASS = !byp; end
      @(negedge CLK);
      aborted = (abort_at > 0) && (c >= abort_at);
      rd_e = (n > 0) && (c <= n + 2) && !aborted;
      wr_e = (n > 0) && (c >= 5) && (c <= n + 4) && !aborted;
      bz_e = (n > 0) && (c <= n + 4) && !((abort_at > 0) && (c > abort_at));
      dn_e = (c == done_c) && (abort_at == 0);
      chk("rd_en", 32'(RD_EN), 32'(rd_e));
      chk("wr_en", 32'(WR_EN), 32'(wr_e));
      chk("busy",  32'(BUSY),  32'(bz_e));
      chk("done",  32'(DONE),  32'(dn_e));
      if (rd_e) begin
        ra = (c <= 2) ? 0 : ((c >= n + 2) ? n - 1 : c - 2);
        chk("rd_addr", 32'(RD_ADDR), 32'(ra));
      end
      @(posedge CLK); #1;
      START = 1'b0; ABORT = 1'b0;
    end
    chk("sb_empty", 32'(sb.size()), 32'd0);
  endtask

  task automatic load_vec(input int i, input bit push);
    for (int j = 0; j < tbl[i].n; j++) begin
      wr_t e;
      mem[j] = tbl[i].x[j];
      e.a = AW'(j); e.d = tbl[i].y[j];
      if (push) sb.push_back(e);
    end
  endtask

  initial begin
    tbl[0] = '{5, 1'b0, {16'd10, 16'd50, 16'd20, 16'd30, 16'd40, 16'd0, 16'd0, 16'd0},
                        {16'd10, 16'd20, 16'd30, 16'd30, 16'd40, 16'd0, 16'd0, 16'd0}};
    tbl[1] = '{1, 1'b0, {16'hABCD, 112'd0}, {16'hABCD, 112'd0}};
    tbl[2] = '{4, 1'b1, {16'd7, 16'd1, 16'd9, 16'd3, 64'd0}, {16'd7, 16'd1, 16'd9, 16'd3, 64'd0}};
    tbl[3] = '{0, 1'b0, 128'd0, 128'd0};
    tbl[4] = '{3, 1'b0, {16'hFFFF, 16'h0000, 16'hFFFF, 80'd0}, {16'hFFFF, 16'hFFFF, 16'hFFFF, 80'd0}};
    tbl[5] = '{6, 1'b0, {16'd60, 16'd10, 16'd40, 16'd20, 16'd50, 16'd30, 32'd0},
                        {16'd60, 16'd40, 16'd20, 16'd40, 16'd30, 16'd30, 32'd0}};
    tbl[6] = '{4, 1'b0, {16'd5, 16'd5, 16'd2, 16'd5, 64'd0}, {16'd5, 16'd5, 16'd5, 16'd5, 64'd0}};
    tbl[7] = '{8, 1'b0, {16'd1, 16'd2, 16'd100, 16'd4, 16'd5, 16'd0, 16'd7, 16'd8},
                        {16'd1, 16'd2, 16'd4, 16'd5, 16'd4, 16'd5, 16'd7, 16'd8}};

    HARD_RESET = 1'b1; START = 1'b0; ABORT = 1'b0; BYPASS = 1'b0; LEN = '0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    chk("rst_rd_en", 32'(RD_EN), 0); chk("rst_wr_en", 32'(WR_EN), 0);
    chk("rst_busy", 32'(BUSY), 0);   chk("rst_done", 32'(DONE), 0);
    chk("rst_rd_addr", 32'(RD_ADDR), 0); chk("rst_wr_addr", 32'(WR_ADDR), 0);
    chk("rst_wr_data", 32'(WR_DATA), 0);
    HARD_RESET = 1'b0;

    for (int i = 0; i < 8; i++) begin
      load_vec(i, 1'b1);
      run_line(tbl[i].n, tbl[i].byp, 0, 0);
    end

    // Abort at cycle 6: only addr0 has been written.
    load_vec(7, 1'b0);
    sb.push_back('{a: '0, d: 16'd1});
    run_line(8, 1'b0, 6, 0);

    // START and ABORT together while idle: the line must not start.
    @(negedge CLK);
    LEN = 3; START = 1'b1; ABORT = 1'b1;
    @(posedge CLK); #1;
    START = 1'b0; ABORT = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge CLK);
      chk("sa_busy", 32'(BUSY), 0); chk("sa_rd_en", 32'(RD_EN), 0); chk("sa_done", 32'(DONE), 0);
    end

    load_vec(4, 1'b1);
    run_line(3, 1'b0, 0, 0);

    // Full-length ramp with a START inside the line that must be ignored.
    for (int j = 0; j < (1 << AW); j++) begin
      wr_t e;
      mem[j] = DW'(j * 7 + 3);
      e.a = AW'(j); e.d = DW'(j * 7 + 3);
      sb.push_back(e);
    end
    run_line(1 << AW, 1'b0, 0, 20);

    // Asynchronous reset mid-line.
    load_vec(7, 1'b0);
    @(negedge CLK);
    LEN = 8; BYPASS = 1'b0; START = 1'b1;
    @(posedge CLK); #1;
    START = 1'b0;
    @(posedge CLK); @(posedge CLK); #2;
    HARD_RESET = 1'b1;
    #1;
    chk("ar_rd_en", 32'(RD_EN), 0); chk("ar_busy", 32'(BUSY), 0);
    chk("ar_rd_addr", 32'(RD_ADDR), 0); chk("ar_wr_en", 32'(WR_EN), 0);
    @(negedge CLK);
    HARD_RESET = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(negedge CLK);
      chk("ar_post_busy", 32'(BUSY), 0); chk("ar_post_done", 32'(DONE), 0);
    end
    chk("ar_sb_empty", 32'(sb.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
